// File: rtl/sram_like_axi_bridge.sv
// SRAM-like responder that turns each accepted request into one single-beat AXI
// read or write, holding at most one transaction in flight.
module sram_like_axi_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] r_data,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] w_data,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

   state_t      state, state_nx;
   logic        aw_done, w_done;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic [2:0]  axi_size;

   // Error responses are deliberately ignored; the transaction completes normally.
   logic unused_resp;
   assign unused_resp = ^{rresp, bresp};

   assign addr_ok = req & (state == S_IDLE) & ~rst;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      arvalid  = 1'b0;
      rready   = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      bready   = 1'b0;
      case (state)
         S_IDLE: if (addr_ok) state_nx = wr ? S_WR : S_AR;
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_nx = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid) state_nx = S_IDLE;
         end
         S_WR: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if ((aw_done | awready) & (w_done | wready)) state_nx = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // AW and W may complete in either order; remember which one already has.
   always_ff @(posedge clk) begin
      if (rst || state != S_WR || state_nx == S_B) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (awready) aw_done <= 1'b1;
         if (wready)  w_done  <= 1'b1;
      end
   end

   // NOTE: the request latches carry no reset; they are only observed while a
   // transaction they were loaded for is in flight.
   always_ff @(posedge clk) begin
      if (addr_ok) begin
         addr_q  <= addr;
         size_q  <= size;
         wdata_q <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata   <= 32'h0;
         data_ok <= 1'b0;
      end else begin
         data_ok <= (state == S_R && rvalid) || (state == S_B && bvalid);
         if (state == S_R && rvalid) rdata <= r_data;
      end
   end

   assign axi_size = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};
   assign araddr   = addr_q;
   assign arsize   = axi_size;
   assign awaddr   = addr_q;
   assign awsize   = axi_size;
   assign w_data   = wdata_q;

   always_comb begin
      case (size_q)
         2'd0:    wstrb = 4'b0001 << addr_q[1:0];
         2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
         default: wstrb = 4'b1111;
      endcase
   end

endmodule
